// File: rtl/memory_pkg.sv
// Shared constants and types for the data memory controller.
package memory_pkg;

  localparam int unsigned DATA_MEM_SIZE_BYTES = 512;
  localparam int unsigned DATA_MEM_LATENCY    = 2;

  typedef enum logic {IDLE, BUSY} mem_state_t;

endpackage

// File: rtl/be_ram.sv
// Word-addressed storage with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module be_ram #(
  parameter int unsigned DEPTH = 128
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [3:0]               be_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  // Byte-masked write, or capture of the addressed word on a read.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int k = 0; k < 4; k++) begin
          if (be_i[k]) mem[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end else begin
        rdata_q <= mem[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-outstanding data memory controller with fixed response latency and
// out-of-range fault reporting.
module data_mem_ctrl
  import memory_pkg::*;
#(
  parameter int unsigned SIZE_BYTES = DATA_MEM_SIZE_BYTES,
  parameter int unsigned LATENCY    = DATA_MEM_LATENCY
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AW    = $clog2(SIZE_BYTES);
  localparam int unsigned DEPTH = SIZE_BYTES / 4;

  mem_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        live_q;
  logic        pend_we_q, pend_err_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept, in_range;
  logic [31:0] ram_rdata;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr_i[1:0];
  assign in_range = (addr_i[31:AW] == '0);
  // live_q keeps ready_o low until the first edge after reset release.
  assign ready_o  = live_q && ((state_q == IDLE) || (cnt_q == 4'd0));
  assign rvalid_o = (state_q == BUSY) && (cnt_q == 4'd0);
  assign accept   = req_i && ready_o;

  be_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .en_i    (accept && in_range),
    .we_i    (we_i),
    .be_i    (be_i),
    .addr_i  (addr_i[AW-1:2]),
    .wdata_i (wdata_i),
    .rdata_o (ram_rdata)
  );

  // Next-state and latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (accept) begin
          cnt_d = 4'(LATENCY - 1);
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Response outputs: live during the response cycle, otherwise the held copy.
  always_comb begin
    rdata_o = rdata_q;
    err_o   = err_q;
    if (rvalid_o) begin
      err_o = pend_err_q;
      if (!pend_we_q) rdata_o = pend_err_q ? 32'h0 : ram_rdata;
    end
  end

  // State, counter, request attributes and held response values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      live_q     <= 1'b0;
      pend_we_q  <= 1'b0;
      pend_err_q <= 1'b0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
      rdata_q <= rdata_o;
      err_q   <= err_o;
      if (accept) begin
        pend_we_q  <= we_i;
        pend_err_q <= !in_range;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: three controller instances at LATENCY 1, 2 and 3.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   [3];
  logic        we    [3];
  logic [3:0]  be    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        ready [3];
  logic        rvalid[3];
  logic [31:0] rdata [3];
  logic        err   [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.SIZE_BYTES(512), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .ready_o(ready[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_o(err[0]));

  data_mem_ctrl #(.SIZE_BYTES(512), .LATENCY(2)) u_l2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .ready_o(ready[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_o(err[1]));

  data_mem_ctrl #(.SIZE_BYTES(512), .LATENCY(3)) u_l3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .we_i(we[2]), .be_i(be[2]),
    .addr_i(addr[2]), .wdata_i(wdata[2]), .ready_o(ready[2]), .rvalid_o(rvalid[2]),
    .rdata_o(rdata[2]), .err_o(err[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on instance i; checks strobe timing, response, and hold afterwards.
  task automatic xact(input int i, input int lat, input logic w, input logic [3:0] b,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err, input string tag);
    @(negedge clk);
    chk({tag, ".ready_pre"}, 32'(ready[i]), 32'd1);
    req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wdata[i] = d;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) req[i] = 1'b0;
      chk({tag, ".rvalid"}, 32'(rvalid[i]), 32'(k == lat));
      chk({tag, ".ready"}, 32'(ready[i]), 32'(k == lat));
    end
    chk({tag, ".rdata"}, rdata[i], exp_rd);
    chk({tag, ".err"}, 32'(err[i]), 32'(exp_err));
    @(negedge clk);
    chk({tag, ".rvalid_after"}, 32'(rvalid[i]), 32'd0);
    chk({tag, ".rdata_hold"}, rdata[i], exp_rd);
    chk({tag, ".err_hold"}, 32'(err[i]), 32'(exp_err));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0; addr[i] = 32'h0; wdata[i] = 32'h0;
    end

    // Reset state
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("rst.ready", 32'(ready[i]), 32'd0);
      chk("rst.rvalid", 32'(rvalid[i]), 32'd0);
      chk("rst.rdata", rdata[i], 32'h0);
      chk("rst.err", 32'(err[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel.ready_before_edge", 32'(ready[1]), 32'd0);
    @(negedge clk);
    chk("rel.ready_first_edge", 32'(ready[1]), 32'd1);

    // LATENCY=2: full and partial writes, reads, faults
    xact(1, 2, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "wr_full");
    xact(1, 2, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "rd_full");
    xact(1, 2, 1'b1, 4'b0101, 32'h10, 32'h11223344, 32'hDEADBEEF, 1'b0, "wr_part");
    xact(1, 2, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDE22BE44, 1'b0, "rd_part");
    xact(1, 2, 1'b1, 4'hF, 32'h1FC, 32'hCAFEF00D, 32'hDE22BE44, 1'b0, "wr_top");
    xact(1, 2, 1'b0, 4'h0, 32'h200, 32'h0, 32'h0, 1'b1, "rd_oor");
    xact(1, 2, 1'b0, 4'h0, 32'h1FC, 32'h0, 32'hCAFEF00D, 1'b0, "rd_top");
    xact(1, 2, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, 32'hCAFEF00D, 1'b0, "wr_be0");
    xact(1, 2, 1'b1, 4'hF, 32'h210, 32'h01234567, 32'hCAFEF00D, 1'b1, "wr_oor");
    xact(1, 2, 1'b0, 4'h0, 32'h13, 32'h0, 32'hDE22BE44, 1'b0, "rd_low_bits");

    // Reset one cycle after a write is accepted
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = 32'h30; wdata[1] = 32'h5A5AA5A5;
    @(negedge clk);
    req[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst.rvalid", 32'(rvalid[1]), 32'd0);
    chk("midrst.ready", 32'(ready[1]), 32'd0);
    chk("midrst.rdata", rdata[1], 32'h0);
    chk("midrst.err", 32'(err[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst.no_rvalid", 32'(rvalid[1]), 32'd0);
    end
    xact(1, 2, 1'b0, 4'h0, 32'h30, 32'h0, 32'h5A5AA5A5, 1'b0, "midrst.rd");

    // LATENCY=3: req held high, one acceptance every 3 cycles
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h40; wdata[2] = 32'h00000A01;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("b2b.rvalid", 32'(rvalid[2]), 32'(k % 3 == 0));
      chk("b2b.ready", 32'(ready[2]), 32'(k % 3 == 0));
      if (k % 3 == 0) begin
        chk("b2b.err", 32'(err[2]), 32'd0);
        wdata[2] = 32'h00000A01 + 32'(k);
      end
      if (k == 9) req[2] = 1'b0;
    end
    @(negedge clk);
    chk("b2b.idle_rvalid", 32'(rvalid[2]), 32'd0);
    chk("b2b.idle_ready", 32'(ready[2]), 32'd1);
    xact(2, 3, 1'b0, 4'h0, 32'h40, 32'h0, 32'h00000A07, 1'b0, "b2b.rd");

    // LATENCY=1: write then read of the same word on consecutive edges
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h50; wdata[0] = 32'h0BADF00D;
    @(negedge clk);
    chk("l1.wr_rvalid", 32'(rvalid[0]), 32'd1);
    chk("l1.wr_ready", 32'(ready[0]), 32'd1);
    chk("l1.wr_err", 32'(err[0]), 32'd0);
    we[0] = 1'b0;
    @(negedge clk);
    req[0] = 1'b0;
    chk("l1.rd_rvalid", 32'(rvalid[0]), 32'd1);
    chk("l1.rd_rdata", rdata[0], 32'h0BADF00D);
    chk("l1.rd_err", 32'(err[0]), 32'd0);
    @(negedge clk);
    chk("l1.idle_rvalid", 32'(rvalid[0]), 32'd0);
    chk("l1.rdata_hold", rdata[0], 32'h0BADF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The module SHALL have parameter SIZE_BYTES, default 512 (memory_pkg DATA_MEM_SIZE_BYTES): storage size in bytes, a power of two and at least 8.
REQ-002 The module SHALL have parameter LATENCY, default 2: cycles from request acceptance to response, legal range 1..15.
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset: clk_i  in  1  rising-edge clock; rst_ni  in  1  asynchronous active-low reset.
REQ-004 The module SHALL have the ports req_i  in  1  request valid; we_i  in  1  1=write, 0=read; be_i  in  4  byte enables for writes; addr_i  in  32  byte address.
REQ-005 The module SHALL have the ports wdata_i  in  32  write data; ready_o  out  1  request can be accepted; rvalid_o  out  1  response strobe; rdata_o  out  32  read data; err_o  out  1  access fault, qualified by rvalid_o.

Function
REQ-006 A request SHALL be accepted on a rising edge where req_i && ready_o; all request inputs are sampled only at that edge.
REQ-007 The word index SHALL be addr_i[$clog2(SIZE_BYTES)-1:2]; addr_i[1:0] is ignored.
REQ-008 An access with addr_i >= SIZE_BYTES SHALL be faulted: no storage write, rdata_o = 0, err_o = 1 with the response.
REQ-009 An accepted in-range write SHALL update exactly the bytes with be_i[k]=1 (byte k = wdata_i[8k+7:8k]) at the accepting edge; be_i = 0 writes nothing and is not an error.
REQ-010 An accepted in-range read SHALL capture the word at the accepting edge, after any write committed at an earlier edge; rdata_o SHALL present it with the response.
REQ-011 The FSM SHALL have states IDLE (ready_o=1) and BUSY (latency counter active).
REQ-012 On acceptance, the FSM SHALL move IDLE->BUSY and load the counter with LATENCY-1.
REQ-013 In BUSY, the counter SHALL decrement each cycle.
REQ-014 When the counter is 0 in BUSY, rvalid_o SHALL be 1 for exactly that cycle and ready_o SHALL be 1.
REQ-015 The response cycle in BUSY SHALL be at cycle T+LATENCY for acceptance at edge T.
REQ-016 In BUSY, ready_o SHALL be 0 in every cycle except the response cycle.
REQ-017 Accepting a new request in the response cycle SHALL keep the FSM in BUSY with the counter reloaded (back-to-back, one request per LATENCY cycles); otherwise the FSM SHALL return to IDLE.
REQ-018 A write response SHALL assert rvalid_o with err_o per REQ-008; rdata_o SHALL hold its previous value.
REQ-019 rdata_o and err_o SHALL hold their last values while rvalid_o=0.
REQ-020 At most one transaction SHALL be outstanding.
REQ-021 req_i while ready_o=0 SHALL be ignored, with no queuing.

Reset
REQ-022 Asserting rst_ni low SHALL, asynchronously, force state IDLE, counter 0, ready_o=0, rvalid_o=0, rdata_o=0 and err_o=0.
REQ-023 After rst_ni deasserts, ready_o SHALL rise on the first clock edge.
REQ-024 Reset mid-transaction SHALL abandon the response; a write already committed at acceptance SHALL remain in storage.
REQ-025 Storage contents SHALL NOT be reset.

Structure
REQ-026 memory_pkg SHALL gain DATA_MEM_LATENCY (default 2) and typedef enum logic {IDLE, BUSY} mem_state_t; SIZE_BYTES defaults from DATA_MEM_SIZE_BYTES.
REQ-027 Storage SHALL be a sub-module be_ram: SIZE_BYTES/4 x 32, synchronous byte-enable write, synchronous read, no reset; the control FSM and counter SHALL remain in data_mem_ctrl.

Verification
REQ-028 The bench SHALL cover: reset, then write addr=0x10, wdata=0xDEADBEEF, be=4'hF, LATENCY=2 -> rvalid_o 2 cycles later, err_o=0; read addr=0x10 -> rdata_o=0xDEADBEEF.
REQ-029 The bench SHALL cover: write addr=0x10, wdata=0x11223344, be=4'b0101 over 0xDEADBEEF -> read returns 0xDE22BE44.
REQ-030 The bench SHALL cover: read addr=0x200 (SIZE_BYTES=512) -> rvalid_o, err_o=1, rdata_o=0; a following read of 0x1FC returns the stored value with err_o=0.
REQ-031 The bench SHALL cover: req_i held high with LATENCY=3 -> accepts every 3 cycles, rvalid_o exactly once per acceptance, ready_o low between.
REQ-032 The bench SHALL cover: rst_ni pulsed low one cycle after a write is accepted -> no rvalid_o, outputs 0, and a later read returns the new data.
REQ-033 The bench SHALL cover: LATENCY=1 with back-to-back write then read of the same address -> read returns the freshly written word.
